// File: rtl/cdc_bit_debounce.sv
// Per-bit glitch filter and edge detector for bits already synchronized into out_clk.
// A change is accepted after DEBOUNCE_CYCLES consecutive samples; acceptance updates level_out and pulses rise/fall.
module cdc_bit_debounce #(
    parameter int                     NUM_OF_BITS     = 1,
    parameter int                     DEBOUNCE_CYCLES = 16,
    parameter logic [NUM_OF_BITS-1:0] RESET_LEVEL     = '0
) (
    input  logic                   out_clk,
    input  logic                   out_reset,
    input  logic                   filter_en,
    input  logic [NUM_OF_BITS-1:0] sync_in,
    output logic [NUM_OF_BITS-1:0] level_out,
    output logic [NUM_OF_BITS-1:0] rise_pulse,
    output logic [NUM_OF_BITS-1:0] fall_pulse,
    output logic                   any_change
);

    localparam int               CNT_W       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam bit               LP_NO_FILT  = (DEBOUNCE_CYCLES == 1);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t                   r_state     [NUM_OF_BITS];
    logic [CNT_W-1:0]         r_cnt       [NUM_OF_BITS];
    logic [NUM_OF_BITS-1:0]   r_level;
    logic [NUM_OF_BITS-1:0]   r_rise;
    logic [NUM_OF_BITS-1:0]   r_fall;
    logic                     r_any_change;

    state_t                   w_state_nxt [NUM_OF_BITS];
    logic [CNT_W-1:0]         w_cnt_nxt   [NUM_OF_BITS];
    logic [NUM_OF_BITS-1:0]   w_level_nxt;
    logic [NUM_OF_BITS-1:0]   w_rise_nxt;
    logic [NUM_OF_BITS-1:0]   w_fall_nxt;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_level_nxt = r_level;
        w_rise_nxt  = '0;
        w_fall_nxt  = '0;
        for (int i = 0; i < NUM_OF_BITS; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];

            if (!filter_en || LP_NO_FILT) begin
                // Bypass drops any pending count and accepts the current sample.
                w_state_nxt[i] = ST_STABLE;
                w_cnt_nxt[i]   = '0;
                if (sync_in[i] != r_level[i]) begin
                    w_level_nxt[i] = sync_in[i];
                    w_rise_nxt[i]  = sync_in[i];
                    w_fall_nxt[i]  = ~sync_in[i];
                end
            end else begin
                case (r_state[i])
                    ST_STABLE: begin
                        w_cnt_nxt[i] = '0;
                        if (sync_in[i] != r_level[i]) begin
                            w_state_nxt[i] = ST_PENDING;
                            w_cnt_nxt[i]   = CNT_W'(1);
                        end
                    end
                    ST_PENDING: begin
                        if (sync_in[i] == r_level[i]) begin
                            w_state_nxt[i] = ST_STABLE;
                            w_cnt_nxt[i]   = '0;
                        end else if (r_cnt[i] == LP_CNT_LAST) begin
                            w_state_nxt[i] = ST_STABLE;
                            w_cnt_nxt[i]   = '0;
                            w_level_nxt[i] = sync_in[i];
                            w_rise_nxt[i]  = sync_in[i];
                            w_fall_nxt[i]  = ~sync_in[i];
                        end else begin
                            w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                        end
                    end
                    default: begin
                        w_state_nxt[i] = ST_STABLE;
                        w_cnt_nxt[i]   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge out_clk or posedge out_reset) begin
        if (out_reset) begin
            // NOTE: state and counters are reset too, so a reset mid-count discards the pending change.
            for (int i = 0; i < NUM_OF_BITS; i++) begin
                r_state[i] <= ST_STABLE;
                r_cnt[i]   <= '0;
            end
            r_level      <= RESET_LEVEL;
            r_rise       <= '0;
            r_fall       <= '0;
            r_any_change <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            for (int i = 0; i < NUM_OF_BITS; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
            r_level      <= w_level_nxt;
            r_rise       <= w_rise_nxt;
            r_fall       <= w_fall_nxt;
            r_any_change <= |{w_rise_nxt, w_fall_nxt};
        end
    end

    assign level_out  = r_level;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;
    assign any_change = r_any_change;

endmodule

// File: tb/tb_cdc_bit_debounce.sv
// Directed bench for cdc_bit_debounce: two channels, 4-sample debounce, reset levels 00 and 11.
module tb_cdc_bit_debounce;

    logic       out_clk;
    logic       out_reset;
    logic       filter_en;
    logic [1:0] sync_in;

    logic [1:0] d_level, d_rise, d_fall;
    logic       d_any;
    logic [1:0] h_level, h_rise, h_fall;
    logic       h_any;

    int n_checks = 0;
    int n_fail   = 0;

    cdc_bit_debounce #(.NUM_OF_BITS(2), .DEBOUNCE_CYCLES(4), .RESET_LEVEL(2'b00)) dut (
        .out_clk    (out_clk),
        .out_reset  (out_reset),
        .filter_en  (filter_en),
        .sync_in    (sync_in),
        .level_out  (d_level),
        .rise_pulse (d_rise),
        .fall_pulse (d_fall),
        .any_change (d_any)
    );

    cdc_bit_debounce #(.NUM_OF_BITS(2), .DEBOUNCE_CYCLES(4), .RESET_LEVEL(2'b11)) dut_rl (
        .out_clk    (out_clk),
        .out_reset  (out_reset),
        .filter_en  (filter_en),
        .sync_in    (sync_in),
        .level_out  (h_level),
        .rise_pulse (h_rise),
        .fall_pulse (h_fall),
        .any_change (h_any)
    );

    initial out_clk = 1'b0;
    always #5 out_clk = ~out_clk;

    // Observation word: {level, rise, fall, any}.
    typedef struct packed {
        logic       fen;
        logic [1:0] sin;
        logic [6:0] exp_obs;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [6:0] obs_d();
        return {d_level, d_rise, d_fall, d_any};
    endfunction

    function automatic logic [6:0] obs_h();
        return {h_level, h_rise, h_fall, h_any};
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got lvl/rise/fall/any=%b expected %b", name, act, exp);
        end
    endtask

    task automatic add(input int n, input logic fen, input logic [1:0] sin,
                       input logic [1:0] lvl, input logic [1:0] rise,
                       input logic [1:0] fall, input logic any);
        vec_t v;
        v.fen     = fen;
        v.sin     = sin;
        v.exp_obs = {lvl, rise, fall, any};
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    // Advance one edge, then sample 1 time unit later; rise/fall exclusivity checked every step.
    task automatic step();
        @(posedge out_clk);
        #1;
        check("rise_fall_exclusive", {3'b000, d_rise & d_fall, h_rise & h_fall}, 7'b0);
    endtask

    initial begin
        out_reset = 1'b1;
        filter_en = 1'b1;
        sync_in   = 2'b00;

        // Test 1: bit0 held high for 4 samples, accepted on the 4th.
        add(3, 1, 2'b01, 2'b00, 2'b00, 2'b00, 0);
        add(1, 1, 2'b01, 2'b01, 2'b01, 2'b00, 1);
        add(1, 1, 2'b01, 2'b01, 2'b00, 2'b00, 0);
        // Test 4: bit0 falls after 4 samples.
        add(3, 1, 2'b00, 2'b01, 2'b00, 2'b00, 0);
        add(1, 1, 2'b00, 2'b00, 2'b00, 2'b01, 1);
        add(1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        // Test 2: 1,1,1,0 glitch restarts the count; 4 fresh ones needed.
        add(3, 1, 2'b01, 2'b00, 2'b00, 2'b00, 0);
        add(1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        add(3, 1, 2'b01, 2'b00, 2'b00, 2'b00, 0);
        add(1, 1, 2'b01, 2'b01, 2'b01, 2'b00, 1);
        add(1, 1, 2'b01, 2'b01, 2'b00, 2'b00, 0);
        add(3, 1, 2'b00, 2'b01, 2'b00, 2'b00, 0);
        add(1, 1, 2'b00, 2'b00, 2'b00, 2'b01, 1);
        // Test 3: both bits rise together, then fall together.
        add(3, 1, 2'b11, 2'b00, 2'b00, 2'b00, 0);
        add(1, 1, 2'b11, 2'b11, 2'b11, 2'b00, 1);
        add(1, 1, 2'b11, 2'b11, 2'b00, 2'b00, 0);
        add(3, 1, 2'b00, 2'b11, 2'b00, 2'b00, 0);
        add(1, 1, 2'b00, 2'b00, 2'b00, 2'b11, 1);
        add(1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        // Test 5: bypass, bit1 toggles every cycle.
        add(1, 0, 2'b10, 2'b10, 2'b10, 2'b00, 1);
        add(1, 0, 2'b00, 2'b00, 2'b00, 2'b10, 1);
        add(1, 0, 2'b10, 2'b10, 2'b10, 2'b00, 1);
        add(1, 0, 2'b00, 2'b00, 2'b00, 2'b10, 1);
        add(1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        // Bypass entered while pending accepts at once; re-enable gives no pulse.
        add(2, 1, 2'b01, 2'b00, 2'b00, 2'b00, 0);
        add(1, 0, 2'b01, 2'b01, 2'b01, 2'b00, 1);
        add(1, 1, 2'b01, 2'b01, 2'b00, 2'b00, 0);
        // Pending count is dropped by bypass; a new change needs a full 4 samples.
        add(1, 1, 2'b00, 2'b01, 2'b00, 2'b00, 0);
        add(1, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0);
        add(3, 1, 2'b00, 2'b01, 2'b00, 2'b00, 0);
        add(1, 1, 2'b00, 2'b00, 2'b00, 2'b01, 1);
        // Independent bits with staggered starts.
        add(1, 1, 2'b01, 2'b00, 2'b00, 2'b00, 0);
        add(2, 1, 2'b11, 2'b00, 2'b00, 2'b00, 0);
        add(1, 1, 2'b11, 2'b01, 2'b01, 2'b00, 1);
        add(1, 1, 2'b11, 2'b11, 2'b10, 2'b00, 1);
        add(1, 1, 2'b11, 2'b11, 2'b00, 2'b00, 0);

        // Reset values, with clock edges running under reset.
        repeat (2) @(posedge out_clk);
        #1;
        check("reset_rl00", obs_d(), 7'b00_00_00_0);
        check("reset_rl11", obs_h(), 7'b11_00_00_0);
        #2 out_reset = 1'b0;

        foreach (vecs[i]) begin
            filter_en = vecs[i].fen;
            sync_in   = vecs[i].sin;
            step();
            check($sformatf("vec%0d", i), obs_d(), vecs[i].exp_obs);
        end

        // Test 6A: reset while level 11 has a fall pending (cnt=2).
        filter_en = 1'b1;
        sync_in   = 2'b00;
        step();
        step();
        check("rstA_pre", obs_d(), 7'b11_00_00_0);
        #2 out_reset = 1'b1;
        #1;
        check("rstA_async_rl00", obs_d(), 7'b00_00_00_0);
        check("rstA_async_rl11", obs_h(), 7'b11_00_00_0);
        #2 out_reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("rstA_post%0d_rl00", k), obs_d(), 7'b00_00_00_0);
            check($sformatf("rstA_post%0d_rl11", k), obs_h(), 7'b11_00_00_0);
        end
        step();
        check("rstA_accept_rl00", obs_d(), 7'b00_00_00_0);
        check("rstA_accept_rl11", obs_h(), 7'b00_00_11_1);
        step();
        check("rstA_quiet_rl11", obs_h(), 7'b00_00_00_0);

        // Test 6B: reset with bit0 rise pending at cnt=2 in both instances.
        sync_in = 2'b01;
        step();
        step();
        check("rstB_pre_rl00", obs_d(), 7'b00_00_00_0);
        check("rstB_pre_rl11", obs_h(), 7'b00_00_00_0);
        #2 out_reset = 1'b1;
        #1;
        check("rstB_async_rl00", obs_d(), 7'b00_00_00_0);
        check("rstB_async_rl11", obs_h(), 7'b11_00_00_0);
        #2 out_reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("rstB_post%0d_rl00", k), obs_d(), 7'b00_00_00_0);
            check($sformatf("rstB_post%0d_rl11", k), obs_h(), 7'b11_00_00_0);
        end
        step();
        check("rstB_accept_rl00", obs_d(), 7'b01_01_00_1);
        check("rstB_accept_rl11", obs_h(), 7'b01_00_10_1);
        step();
        check("rstB_quiet_rl00", obs_d(), 7'b01_00_00_0);
        check("rstB_quiet_rl11", obs_h(), 7'b01_00_00_0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
